rc4_prga_decrypt: RTL and testbench

- RC4 keystream generator and decryptor; runs after key scheduling has left a permuted S in s_memory.
- Reads S, performs the PRGA swap per byte, and XORs each keystream byte with the encrypted_message ROM.
- Writes the result to the decrypted_message RAM.
- Started and acknowledged by state_machine_control through a start/finish level handshake, and muxed onto the s_memory port like the init and shuffle FSMs.

---
 rtl/rc4_pkg.sv | 25 ++
 rtl/rc4_prga_decrypt_if.sv | 34 +++
 rtl/rc4_prga_decrypt.sv | 162 ++++++++++++++++
 tb/tb_rc4_prga_decrypt.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rc4_pkg.sv
// Shared RC4 definitions: byte/table geometry and the PRGA state encoding,
// kept in the same sequential enum style as the init and shuffle FSMs.
package rc4_pkg;

  localparam int BYTE_W               = 8;
  localparam int S_DEPTH              = 256;
  localparam int PRGA_CYCLES_PER_BYTE = 11;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_INC_I,
    ST_WAIT_SI,
    ST_READ_SI,
    ST_WAIT_SJ,
    ST_READ_SJ,
    ST_WRITE_SI,
    ST_WRITE_SJ,
    ST_READ_F,
    ST_WAIT_F,
    ST_WRITE_D,
    ST_NEXT,
    ST_DONE
  } rc4_state_e;

endpackage

// File: rtl/rc4_prga_decrypt_if.sv
// Control handshake plus the s_memory, encrypted_message and decrypted_message
// ports of the PRGA decryptor, bundled for the top-level mux.
interface rc4_prga_decrypt_if #(
  parameter int MSG_AW = 5
);
  import rc4_pkg::*;

  // start/finish is a level handshake: start is held high to request a run,
  // finish is held high once the run is complete, and a new run is only
  // accepted after start has been dropped (finish falls with it).
  logic              start;
  logic              finish;
  logic              busy;
  logic [BYTE_W-1:0] s_addr;
  logic [BYTE_W-1:0] s_wdata;
  logic              s_wren;
  logic [BYTE_W-1:0] s_q;
  logic [MSG_AW-1:0] e_addr;
  logic [BYTE_W-1:0] e_q;
  logic [MSG_AW-1:0] d_addr;
  logic [BYTE_W-1:0] d_wdata;
  logic              d_wren;

  modport master (
    input  start, s_q, e_q,
    output finish, busy, s_addr, s_wdata, s_wren, e_addr, d_addr, d_wdata, d_wren
  );

  modport slave (
    output start, s_q, e_q,
    input  finish, busy, s_addr, s_wdata, s_wren, e_addr, d_addr, d_wdata, d_wren
  );

endinterface

// File: rtl/rc4_prga_decrypt.sv
// RC4 keystream generator: walks the permuted S table, swaps per byte and XORs
// the keystream with the encrypted ROM into the decrypted RAM.
module rc4_prga_decrypt
  import rc4_pkg::*;
#(
  parameter int MSG_LEN = 32,
  parameter int MSG_AW  = 5
) (
  input  logic               clk,
  input  logic               reset,
  rc4_prga_decrypt_if.master bus,
  output rc4_state_e         state_o
);

  localparam int                IDX_W  = $clog2(S_DEPTH);
  localparam logic [MSG_AW-1:0] K_LAST = MSG_AW'(MSG_LEN - 1);

  rc4_state_e        state_q, state_d;
  logic [IDX_W-1:0]  i_q, i_d, j_q, j_d;
  logic [MSG_AW-1:0] k_q, k_d;
  logic [BYTE_W-1:0] si_q, si_d, sj_q, sj_d, enc_q, enc_d;
  logic              finish_q, finish_d;
  logic [IDX_W-1:0]  f_idx;

  logic              busy;
  logic [BYTE_W-1:0] s_addr, s_wdata, d_wdata;
  logic              s_wren, d_wren;
  logic [MSG_AW-1:0] e_addr, d_addr;

  assign f_idx = si_q + sj_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      i_q      <= '0;
      j_q      <= '0;
      k_q      <= '0;
      si_q     <= '0;
      sj_q     <= '0;
      enc_q    <= '0;
      finish_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      i_q      <= i_d;
      j_q      <= j_d;
      k_q      <= k_d;
      si_q     <= si_d;
      sj_q     <= sj_d;
      enc_q    <= enc_d;
      finish_q <= finish_d;
    end
  end

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    si_d    = si_q;
    sj_d    = sj_q;
    enc_d   = enc_q;
    // finish rises one edge after DONE is entered and drops together with start.
    finish_d = (state_q == ST_DONE) && bus.start;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_INC_I;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
        end
      end
      ST_INC_I: begin
        i_d     = i_q + IDX_W'(1);
        state_d = ST_WAIT_SI;
      end
      ST_WAIT_SI: state_d = ST_READ_SI;
      ST_READ_SI: begin
        si_d    = bus.s_q;
        j_d     = j_q + bus.s_q;
        enc_d   = bus.e_q;
        state_d = ST_WAIT_SJ;
      end
      ST_WAIT_SJ: state_d = ST_READ_SJ;
      ST_READ_SJ: begin
        sj_d    = bus.s_q;
        state_d = ST_WRITE_SI;
      end
      ST_WRITE_SI: state_d = ST_WRITE_SJ;
      ST_WRITE_SJ: state_d = ST_READ_F;
      ST_READ_F:   state_d = ST_WAIT_F;
      ST_WAIT_F:   state_d = ST_WRITE_D;
      ST_WRITE_D:  state_d = ST_NEXT;
      ST_NEXT: begin
        if (k_q == K_LAST) begin
          state_d = ST_DONE;
        end else begin
          k_d     = k_q + MSG_AW'(1);
          state_d = ST_INC_I;
        end
      end
      ST_DONE: begin
        if (!bus.start) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Memory addresses are registered inside the RAMs, so each address is held
  // through its wait and capture states.
  always_comb begin
    busy    = (state_q != ST_IDLE) && (state_q != ST_DONE);
    s_addr  = '0;
    s_wdata = '0;
    s_wren  = 1'b0;
    e_addr  = '0;
    d_addr  = '0;
    d_wdata = '0;
    d_wren  = 1'b0;
    case (state_q)
      ST_INC_I: begin
        s_addr = i_q + IDX_W'(1);
        e_addr = k_q;
      end
      ST_WAIT_SI, ST_READ_SI: begin
        s_addr = i_q;
        e_addr = k_q;
      end
      ST_WAIT_SJ, ST_READ_SJ: s_addr = j_q;
      ST_WRITE_SI: begin
        s_addr  = i_q;
        s_wdata = sj_q;
        s_wren  = 1'b1;
      end
      ST_WRITE_SJ: begin
        s_addr  = j_q;
        s_wdata = si_q;
        s_wren  = 1'b1;
      end
      ST_READ_F, ST_WAIT_F: s_addr = f_idx;
      ST_WRITE_D: begin
        s_addr  = f_idx;
        d_addr  = k_q;
        d_wdata = bus.s_q ^ enc_q;
        d_wren  = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.finish  = finish_q;
  assign bus.busy    = busy;
  assign bus.s_addr  = s_addr;
  assign bus.s_wdata = s_wdata;
  assign bus.s_wren  = s_wren;
  assign bus.e_addr  = e_addr;
  assign bus.d_addr  = d_addr;
  assign bus.d_wdata = d_wdata;
  assign bus.d_wren  = d_wren;
  assign state_o     = state_q;

endmodule

// File: tb/tb_rc4_prga_decrypt.sv
// Bench for rc4_prga_decrypt: four instances (2, 9, 32 and 260 byte messages)
// each with its own registered-address memory models.
module tb_rc4_prga_decrypt;
  import rc4_pkg::*;

  localparam int NI      = 4;
  localparam int LEN[NI] = '{2, 9, 32, 260};

  typedef struct {
    int         inst;
    bit         is_s;
    int         addr;
    logic [7:0] exp;
  } vec_t;

  logic       clk;
  logic       reset_n;
  logic       start      [NI];
  logic       finish_w   [NI];
  logic       busy_w     [NI];
  logic       s_wren_w   [NI];
  logic       d_wren_w   [NI];
  logic [7:0] s_addr_w   [NI];
  logic [7:0] s_wdata_w  [NI];
  logic [7:0] d_wdata_w  [NI];
  logic [15:0] e_addr_w  [NI];
  logic [15:0] d_addr_w  [NI];
  rc4_state_e state_w    [NI];

  logic [7:0] s_mem [NI][256];
  logic [7:0] e_mem [NI][512];
  logic [7:0] d_mem [NI][512];
  int         s_wren_cnt    [NI];
  int         d_wren_cnt    [NI];
  int         busy_done_cnt [NI];

  logic [7:0] m_s     [256];
  logic [7:0] saved_s [256];
  logic [7:0] exp_q   [$];
  vec_t       vecs    [15];
  int         n_checks;
  int         n_errors;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  for (genvar g = 0; g < NI; g++) begin : g_inst
    localparam int N  = LEN[g];
    localparam int AW = (N > 1) ? $clog2(N) : 1;

    rc4_prga_decrypt_if #(.MSG_AW(AW)) bus ();
    logic [7:0]    s_addr_r;
    logic [AW-1:0] e_addr_r;

    rc4_prga_decrypt #(.MSG_LEN(N), .MSG_AW(AW)) dut (
      .clk    (clk),
      .reset  (reset_n),
      .bus    (bus.master),
      .state_o(state_w[g])
    );

    assign bus.start = start[g];
    assign bus.s_q   = s_mem[g][s_addr_r];
    assign bus.e_q   = e_mem[g][9'(e_addr_r)];

    always @(posedge clk) begin
      s_addr_r <= bus.s_addr;
      e_addr_r <= bus.e_addr;
      if (bus.s_wren) begin
        s_mem[g][bus.s_addr] = bus.s_wdata;
        s_wren_cnt[g]++;
      end
      if (bus.d_wren) begin
        d_mem[g][9'(bus.d_addr)] = bus.d_wdata;
        d_wren_cnt[g]++;
      end
      if (bus.busy && state_w[g] == ST_DONE) busy_done_cnt[g]++;
    end

    assign finish_w[g]  = bus.finish;
    assign busy_w[g]    = bus.busy;
    assign s_wren_w[g]  = bus.s_wren;
    assign d_wren_w[g]  = bus.d_wren;
    assign s_addr_w[g]  = bus.s_addr;
    assign s_wdata_w[g] = bus.s_wdata;
    assign d_wdata_w[g] = bus.d_wdata;
    assign e_addr_w[g]  = 16'(bus.e_addr);
    assign d_addr_w[g]  = 16'(bus.d_addr);
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic chk_outs_zero(input int g, input string nm);
    chk($sformatf("%s_outs%0d", nm, g),
        {finish_w[g], busy_w[g], s_wren_w[g], d_wren_w[g], s_addr_w[g],
         s_wdata_w[g], d_wdata_w[g], e_addr_w[g], d_addr_w[g]}, 64'd0);
    chk($sformatf("%s_state%0d", nm, g), state_w[g], ST_IDLE);
  endtask

  // reference RC4 PRGA over the current S of instance g
  task automatic model_run(input int g);
    int i, j;
    logic [7:0] t, f;
    for (int x = 0; x < 256; x++) m_s[x] = s_mem[g][x];
    exp_q.delete();
    i = 0;
    j = 0;
    for (int k = 0; k < LEN[g]; k++) begin
      i = (i + 1) % 256;
      j = (j + int'(m_s[i])) % 256;
      t = m_s[i];
      m_s[i] = m_s[j];
      m_s[j] = t;
      f = m_s[i] + m_s[j];
      exp_q.push_back(m_s[f] ^ e_mem[g][k]);
    end
  endtask

  task automatic ksa_key(input int g);
    logic [7:0] key [3];
    logic [7:0] t;
    int j;
    key = '{8'h4B, 8'h65, 8'h79};
    for (int x = 0; x < 256; x++) s_mem[g][x] = 8'(x);
    j = 0;
    for (int i = 0; i < 256; i++) begin
      j = (j + int'(s_mem[g][i]) + int'(key[i % 3])) % 256;
      t = s_mem[g][i];
      s_mem[g][i] = s_mem[g][j];
      s_mem[g][j] = t;
    end
  endtask

  task automatic rand_fill(input int g);
    logic [7:0] t;
    int y;
    for (int x = 0; x < 256; x++) s_mem[g][x] = 8'(x);
    for (int x = 255; x > 0; x--) begin
      y = $urandom_range(0, x);
      t = s_mem[g][x];
      s_mem[g][x] = s_mem[g][y];
      s_mem[g][y] = t;
    end
    for (int k = 0; k < LEN[g]; k++) e_mem[g][k] = 8'($urandom_range(0, 255));
  endtask

  task automatic run_check(input int g);
    int n, edges, bad;
    logic [7:0] exp_b;
    n = LEN[g];
    model_run(g);
    s_wren_cnt[g] = 0;
    d_wren_cnt[g] = 0;
    @(negedge clk);
    start[g] = 1'b1;
    @(posedge clk);
    edges = 0;
    do begin
      @(posedge clk);
      edges++;
      #1;
    end while (!finish_w[g] && edges < PRGA_CYCLES_PER_BYTE * n + 20);
    chk($sformatf("latency%0d", g), edges, PRGA_CYCLES_PER_BYTE * n + 1);
    repeat (4) @(posedge clk);
    #1;
    chk($sformatf("finish_hold%0d", g), finish_w[g], 1);
    chk($sformatf("no_restart%0d", g), {busy_w[g], state_w[g]}, {1'b0, ST_DONE});
    @(negedge clk);
    start[g] = 1'b0;
    @(posedge clk);
    #1;
    chk($sformatf("finish_fall%0d", g), finish_w[g], 0);
    chk($sformatf("back_idle%0d", g), state_w[g], ST_IDLE);
    repeat (5) @(posedge clk);
    #1;
    chk($sformatf("stay_idle%0d", g), {busy_w[g], state_w[g]}, {1'b0, ST_IDLE});
    chk($sformatf("s_wren_cycles%0d", g), s_wren_cnt[g], 2 * n);
    chk($sformatf("d_wren_cycles%0d", g), d_wren_cnt[g], n);
    for (int k = 0; k < n; k++) begin
      exp_b = exp_q.pop_front();
      chk($sformatf("d%0d_%0d", g, k), d_mem[g][k], exp_b);
    end
    bad = 0;
    for (int x = 0; x < 256; x++) if (s_mem[g][x] !== m_s[x]) bad++;
    chk($sformatf("final_s%0d", g), bad, 0);
  endtask

  initial begin
    logic [7:0] ct [9];
    logic [7:0] pt [9];
    int cnt;
    ct = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
    pt = '{8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
    vecs[0] = '{0, 1'b0, 0, 8'h02};
    vecs[1] = '{0, 1'b0, 1, 8'hFA};
    vecs[2] = '{0, 1'b1, 2, 8'h03};
    vecs[3] = '{0, 1'b1, 3, 8'h02};
    vecs[4] = '{0, 1'b1, 1, 8'h01};
    vecs[5] = '{0, 1'b1, 5, 8'h05};
    for (int k = 0; k < 9; k++) vecs[6 + k] = '{1, 1'b0, k, pt[k]};

    n_checks = 0;
    n_errors = 0;
    for (int g = 0; g < NI; g++) begin
      start[g] = 1'b0;
      s_wren_cnt[g] = 0;
      d_wren_cnt[g] = 0;
      busy_done_cnt[g] = 0;
    end
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int g = 0; g < NI; g++) chk_outs_zero(g, "reset");
    @(negedge clk);
    reset_n = 1'b1;

    // identity S, i==j on byte 0
    for (int x = 0; x < 256; x++) s_mem[0][x] = 8'(x);
    e_mem[0][0] = 8'h00;
    e_mem[0][1] = 8'hFF;
    run_check(0);

    // S from KSA with key "Key"
    ksa_key(1);
    for (int k = 0; k < 9; k++) e_mem[1][k] = ct[k];
    run_check(1);

    // 32-byte run, then reset during byte 5 WRITE_SI and restart
    rand_fill(2);
    for (int x = 0; x < 256; x++) saved_s[x] = s_mem[2][x];
    run_check(2);
    for (int x = 0; x < 256; x++) s_mem[2][x] = saved_s[x];
    @(negedge clk);
    start[2] = 1'b1;
    cnt = 0;
    for (int c = 0; c < 200 && cnt < 6; c++) begin
      @(posedge clk);
      #1;
      if (state_w[2] == ST_WRITE_SI) cnt++;
    end
    chk("reset_locate", cnt, 6);
    reset_n = 1'b0;
    start[2] = 1'b0;
    @(posedge clk);
    #1;
    chk_outs_zero(2, "midrun_reset");
    @(negedge clk);
    reset_n = 1'b1;
    for (int x = 0; x < 256; x++) s_mem[2][x] = saved_s[x];
    run_check(2);

    // 260 bytes: i wraps past 255
    rand_fill(3);
    run_check(3);

    for (int v = 0; v < 15; v++) begin
      if (vecs[v].is_s)
        chk($sformatf("vec%0d_s", v), s_mem[vecs[v].inst][vecs[v].addr], vecs[v].exp);
      else
        chk($sformatf("vec%0d_d", v), d_mem[vecs[v].inst][vecs[v].addr], vecs[v].exp);
    end
    for (int g = 0; g < NI; g++)
      chk($sformatf("busy_in_done%0d", g), busy_done_cnt[g], 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
